// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART receive types, byte width and baud-divider helper.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Truncating divide: the residual baud error is absorbed by centre sampling.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_byte
//  Purpose  : 8N1 byte receiver: 2-flop synchroniser, bit-centre sampling FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1302
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_i,
    output logic [UART_BYTE_W-1:0] byte_o,
    output logic                   byte_stb_o,
    output logic                   stop_err_o,
    output logic                   busy_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(UART_BYTE_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_BYTE_W - 1);

    logic [1:0]             sync_q;
    rx_state_t              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BIT_W-1:0]       bit_q;
    logic [UART_BYTE_W-1:0] shift_q;
    logic [UART_BYTE_W-1:0] byte_q;
    logic                   byte_stb_q;
    logic                   stop_err_q;
    logic                   rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 2'b11;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            byte_stb_q <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_i};
            byte_stb_q <= 1'b0;
            stop_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) state_q <= START;
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[UART_BYTE_W-1:1]};
                        if (bit_q == BIT_LAST) state_q <= STOP;
                        else                   bit_q   <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at the stop-bit centre so a fast host is tolerated.
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rx_s) begin
                            byte_q     <= shift_q;
                            byte_stb_q <= 1'b1;
                        end else begin
                            stop_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_o     = byte_q;
    assign byte_stb_o = byte_stb_q;
    assign stop_err_o = stop_err_q;
    assign busy_o     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_rx_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_word_assembler
//  Purpose  : Packs received byte pairs (high first) into a valid/ready word
//             stream with frame indexing. Optional inter-byte timeout enabled
//             by defining UART_RX_BYTE_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word_assembler
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 12_500_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned WORD_W       = 16,
    parameter int unsigned NUM_WORDS    = 17
`ifdef UART_RX_BYTE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_BITS = 20
`endif
) (
    input  logic                         sysclk,
    input  logic                         rstn,
    input  logic                         uart_txd_in,
    output logic [WORD_W-1:0]            word_data,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(NUM_WORDS)-1:0] word_idx,
    output logic                         frame_done,
    output logic                         frame_err,
    output logic                         overrun,
    output logic                         rx_busy
);

    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

    logic [UART_BYTE_W-1:0] rx_byte;
    logic                   rx_stb;
    logic                   rx_stop_err;
    logic                   rx_busy_w;
    logic                   timeout;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB)
    ) u_rx_byte (
        .clk_i      (sysclk),
        .rst_ni     (rstn),
        .rx_i       (uart_txd_in),
        .byte_o     (rx_byte),
        .byte_stb_o (rx_stb),
        .stop_err_o (rx_stop_err),
        .busy_o     (rx_busy_w)
    );

    logic                   hi_pending_q, hi_pending_d;
    logic [UART_BYTE_W-1:0] hi_byte_q,    hi_byte_d;
    logic [WORD_W-1:0]      word_data_q,  word_data_d;
    logic                   word_valid_q, word_valid_d;
    logic [IDX_W-1:0]       word_idx_q,   word_idx_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_err_q,  frame_err_d;
    logic                   overrun_q,    overrun_d;
    logic                   xfer;
    logic                   word_done;

`ifdef UART_RX_BYTE_TIMEOUT_EN
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CPB;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Only idle line time counts; any reception in progress restarts the wait.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= '0;
        end else if (!hi_pending_q || rx_busy_w) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout = hi_pending_q && !rx_busy_w && (to_cnt_q == TO_W'(TO_LIMIT - 1));
`else
    assign timeout = 1'b0;
`endif

    assign xfer      = word_valid_q && word_ready;
    assign word_done = rx_stb && hi_pending_q;

    always_comb begin
        hi_pending_d = hi_pending_q;
        hi_byte_d    = hi_byte_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        word_idx_d   = word_idx_q;
        frame_done_d = 1'b0;
        frame_err_d  = rx_stop_err || timeout;
        overrun_d    = 1'b0;

        if (rx_stop_err || timeout) begin
            hi_pending_d = 1'b0;
        end else if (rx_stb) begin
            if (!hi_pending_q) begin
                hi_byte_d    = rx_byte;
                hi_pending_d = 1'b1;
            end else begin
                hi_pending_d = 1'b0;
            end
        end

        if (xfer) begin
            word_valid_d = 1'b0;
            if (word_idx_q == IDX_LAST) begin
                word_idx_d   = '0;
                frame_done_d = 1'b1;
            end else begin
                word_idx_d = word_idx_q + 1'b1;
            end
        end

        // A word arriving alongside a transfer refills the slot being freed.
        if (word_done) begin
            if (word_valid_q && !xfer) begin
                overrun_d = 1'b1;
            end else begin
                word_data_d  = WORD_W'({hi_byte_q, rx_byte});
                word_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            hi_pending_q <= 1'b0;
            hi_byte_q    <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            word_idx_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            hi_pending_q <= hi_pending_d;
            hi_byte_q    <= hi_byte_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            word_idx_q   <= word_idx_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign word_idx   = word_idx_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign rx_busy    = rx_busy_w;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_word_assembler
//  Purpose  : Directed self-checking bench for uart_rx_word_assembler.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_word_assembler;

    // 1 MHz / 62.5 kbaud = 16 clocks per bit keeps whole frames short.
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        txd = 1'b1;
    logic        word_ready = 1'b0;
    logic [15:0] word_data;
    logic        word_valid;
    logic [4:0]  word_idx;
    logic        frame_done;
    logic        frame_err;
    logic        overrun;
    logic        rx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_word_assembler #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (62_500),
        .WORD_W      (16),
        .NUM_WORDS   (17)
    ) dut (
        .sysclk      (clk),
        .rstn        (rstn),
        .uart_txd_in (txd),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_idx    (word_idx),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .rx_busy     (rx_busy)
    );

    // Observation of accepted words and pulses, sampled on the falling edge.
    logic [15:0] acc_data[$];
    logic [4:0]  acc_idx[$];
    int          n_done = 0, n_ferr = 0, n_ovr = 0, n_unstable = 0, done_at = -1, n_busy = 0;
    logic        hold_prev = 1'b0;
    logic [15:0] held_data = '0;
    logic [4:0]  held_idx = '0;

    always @(negedge clk) begin
        if (rstn) begin
            if (word_valid && word_ready) begin
                acc_data.push_back(word_data);
                acc_idx.push_back(word_idx);
            end
            if (frame_done) begin n_done++; done_at = acc_data.size(); end
            if (frame_err)  n_ferr++;
            if (overrun)    n_ovr++;
            if (rx_busy)    n_busy++;
            if (hold_prev && (word_data !== held_data || word_idx !== held_idx)) n_unstable++;
            hold_prev = word_valid && !word_ready;
            held_data = word_data;
            held_idx  = word_idx;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        txd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            txd = b[i];
            tick(CPB);
        end
        txd = stop_bit;
        tick(CPB);
        txd = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(2);
    endtask

    int base, ferr0, ovr0, done0, busy0;

    initial begin
        tick(3);
        // Reset state, sampled while rstn is still low
        check_eq("rst_data",  32'(word_data),  32'h0);
        check_eq("rst_valid", 32'(word_valid), 32'h0);
        check_eq("rst_idx",   32'(word_idx),   32'h0);
        check_eq("rst_fdone", 32'(frame_done), 32'h0);
        check_eq("rst_ferr",  32'(frame_err),  32'h0);
        check_eq("rst_ovr",   32'(overrun),    32'h0);
        check_eq("rst_busy",  32'(rx_busy),    32'h0);
        rstn = 1'b1;
        tick(2);

        // 1: single word 0xABCD
        word_ready = 1'b1;
        base = acc_data.size(); ferr0 = n_ferr; ovr0 = n_ovr;
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        check_eq("t1_count", 32'(acc_data.size() - base), 32'd1);
        if (acc_data.size() > base) begin
            check_eq("t1_data", 32'(acc_data[base]), 32'hABCD);
            check_eq("t1_idx",  32'(acc_idx[base]),  32'h0);
        end
        check_eq("t1_ferr",   32'(n_ferr - ferr0), 32'd0);
        check_eq("t1_ovr",    32'(n_ovr - ovr0),   32'd0);
        check_eq("t1_idxnow", 32'(word_idx),       32'd1);

        // 2: full frame of 17 words
        do_reset();
        base = acc_data.size(); done0 = n_done;
        for (int w = 0; w < 17; w++) begin
            send_byte(8'h00, 1'b1);
            send_byte(8'(w), 1'b1);
        end
        check_eq("t2_count", 32'(acc_data.size() - base), 32'd17);
        if (acc_data.size() >= base + 17) begin
            for (int k = 0; k < 17; k++) begin
                check_eq("t2_data", 32'(acc_data[base + k]), 32'(k));
                check_eq("t2_idx",  32'(acc_idx[base + k]),  32'(k));
            end
        end
        check_eq("t2_fdone",   32'(n_done - done0), 32'd1);
        check_eq("t2_done_at", 32'(done_at),        32'(base + 17));
        check_eq("t2_idxwrap", 32'(word_idx),       32'd0);

        // 3: backpressure, second word overruns
        do_reset();
        word_ready = 1'b0;
        base = acc_data.size(); ovr0 = n_ovr;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        check_eq("t3_held",     32'(word_data),     32'h1122);
        check_eq("t3_valid",    32'(word_valid),    32'h1);
        check_eq("t3_idx",      32'(word_idx),      32'h0);
        check_eq("t3_ovr",      32'(n_ovr - ovr0),  32'd1);
        check_eq("t3_unstable", 32'(n_unstable),    32'd0);
        word_ready = 1'b1;
        tick(2);
        check_eq("t3_count", 32'(acc_data.size() - base), 32'd1);
        if (acc_data.size() > base)
            check_eq("t3_acc", 32'(acc_data[base]), 32'h1122);
        check_eq("t3_idx_after",   32'(word_idx),   32'd1);
        check_eq("t3_valid_after", 32'(word_valid), 32'd0);

        // 4: bad stop bit on the high byte
        do_reset();
        base = acc_data.size(); ferr0 = n_ferr;
        send_byte(8'hEE, 1'b0);
        check_eq("t4_ferr",    32'(n_ferr - ferr0),           32'd1);
        check_eq("t4_noword",  32'(acc_data.size() - base),   32'd0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check_eq("t4_count", 32'(acc_data.size() - base), 32'd1);
        if (acc_data.size() > base)
            check_eq("t4_data", 32'(acc_data[base]), 32'h1234);

        // 5: short low glitch on idle line
        do_reset();
        base = acc_data.size(); ferr0 = n_ferr; busy0 = n_busy;
        txd = 1'b0;
        tick(3);
        txd = 1'b1;
        tick(2 * CPB);
        check_eq("t5_busy_seen", 32'(n_busy > busy0),         32'd1);
        check_eq("t5_busy_low",  32'(rx_busy),                32'd0);
        check_eq("t5_ferr",      32'(n_ferr - ferr0),         32'd0);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        check_eq("t5_count", 32'(acc_data.size() - base), 32'd1);
        if (acc_data.size() > base)
            check_eq("t5_data", 32'(acc_data[base]), 32'h5678);

`ifdef UART_RX_BYTE_TIMEOUT_EN
        // 6: inter-byte timeout resynchronises pairing
        do_reset();
        base = acc_data.size(); ferr0 = n_ferr;
        send_byte(8'h55, 1'b1);
        tick(25 * CPB);
        check_eq("t6_ferr", 32'(n_ferr - ferr0), 32'd1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        check_eq("t6_count", 32'(acc_data.size() - base), 32'd1);
        if (acc_data.size() > base)
            check_eq("t6_data", 32'(acc_data[base]), 32'h6677);
`endif

        // 7: asynchronous reset mid-byte with a word held
        do_reset();
        word_ready = 1'b0;
        send_byte(8'h9A, 1'b1);
        send_byte(8'hBC, 1'b1);
        check_eq("t7_pre_valid", 32'(word_valid), 32'd1);
        txd = 1'b0;
        tick(3 * CPB);
        check_eq("t7_pre_busy", 32'(rx_busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("t7_rst_valid", 32'(word_valid), 32'd0);
        check_eq("t7_rst_data",  32'(word_data),  32'd0);
        check_eq("t7_rst_busy",  32'(rx_busy),    32'd0);
        txd = 1'b1;
        word_ready = 1'b1;
        tick(3);
        rstn = 1'b1;
        tick(2);
        base = acc_data.size();
        send_byte(8'hDE, 1'b1);
        send_byte(8'hF0, 1'b1);
        check_eq("t7_count", 32'(acc_data.size() - base), 32'd1);
        if (acc_data.size() > base) begin
            check_eq("t7_data", 32'(acc_data[base]), 32'hDEF0);
            check_eq("t7_idx",  32'(acc_idx[base]),  32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
